i3c_bus_condition_monitor: RTL
==============================

# i3c_bus_condition_monitor

Parametrised I3C bus-condition monitor sitting beside the controller/target FSMs, fed by the synchronised, deglitched bus state. Detects HDR Exit, HDR Restart and Target Reset patterns with configurable SDA-toggle counts. Measures bus-free, bus-available and bus-idle intervals with saturating timers against runtime thresholds. All detections are registered one-cycle pulses; timer conditions are registered levels.

## Interface
Parameters:
- TimerW, 20, width of the bus-idle timer and threshold ports
- HdrRestartFalls, 2, SDA falling edges (SCL low) forming the HDR Restart pattern
- HdrExitFalls, 4, SDA falling edges (SCL low) forming the HDR Exit pattern
- TgtRstFalls, 7, SDA falling edges (SCL low) forming the Target Reset pattern prefix
- CntW, 4, falling-edge counter width; must hold TgtRstFalls+1

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- enable_i  in  1  monitor enable; low clears all state
- bus_i  in  bus_state_t  fields used: scl/sda .stable_high, .stable_low, .pos_edge, .neg_edge; start_det; stop_det
- is_in_hdr_mode_i  in  1  device currently in HDR mode
- t_free_i  in  TimerW  bus-free threshold, clk cycles
- t_avail_i  in  TimerW  bus-available threshold, clk cycles
- t_idle_i  in  TimerW  bus-idle threshold, clk cycles
- hdr_restart_detect_o  out  1  pulse, HDR Restart seen
- hdr_exit_detect_o  out  1  pulse, HDR Exit seen
- target_reset_detect_o  out  1  pulse, Target Reset seen
- bus_free_o  out  1  level, bus free for ≥ t_free_i
- bus_available_o  out  1  level, bus free for ≥ t_avail_i
- bus_idle_o  out  1  level, bus free for ≥ t_idle_i

## Operation
- Falling-edge counter fcnt (CntW, saturating at all-ones): +1 on sda.neg_edge while scl.stable_low; cleared on scl.pos_edge, start_det, stop_det (after evaluation below), or !enable_i.
- HDR path (is_in_hdr_mode_i=1):
  - scl.pos_edge with fcnt==HdrRestartFalls and sda.stable_high → hdr_restart_detect_o pulse.
  - fcnt ≥ HdrExitFalls sets exit_armed; stop_det with exit_armed → hdr_exit_detect_o pulse; exit_armed cleared by that stop, by scl.pos_edge without stop, or !enable_i.
  - fcnt == HdrExitFalls at scl.pos_edge is not a restart.
- Target Reset FSM (active in SDR and HDR): IDLE → ARMED when fcnt reaches TgtRstFalls; ARMED → WAIT_P on start_det (Sr); WAIT_P → IDLE on stop_det, pulsing target_reset_detect_o. ARMED/WAIT_P → IDLE on scl.neg_edge (clocked data), on stop_det seen in ARMED (no Sr), or !enable_i. In ARMED, extra SDA falls are ignored.
- When TgtRstFalls pattern completes in HDR, exit_armed is also set; the following Sr suppresses the HDR exit (the exit requires stop_det without prior start_det while armed).
- Bus timer tcnt (TimerW, saturating): cleared by start_det, any SCL/SDA edge, either line not stable_high, or !enable_i; starts counting on the cycle after stop_det while both lines stable_high; holds at all-ones.
- bus_free_o = (tcnt ≥ t_free_i) && counting; likewise available/idle. Threshold 0 asserts one cycle after stop_det. Thresholds may change anytime; comparison is live.
- !enable_i: counters, FSM, exit_armed cleared; all outputs 0 the next cycle.

## Timing
- Reset values: all outputs 0, fcnt=0, tcnt=0, FSM=IDLE, exit_armed=0.
- Detect pulses: exactly one cycle, asserted the cycle after the qualifying stop_det / scl.pos_edge sample.
- Timer outputs: registered; rise the cycle after tcnt crosses threshold, fall the cycle after the clearing event.
- Simultaneous stop_det and start_det: start wins for FSM (→WAIT_P path) and clears timer.
- Reset mid-pattern: asynchronous return to reset values, no pulse.

## Test plan
- HDR mode, SCL low, 4 SDA falls, STOP → hdr_exit_detect_o one pulse 1 cycle after stop_det; no restart pulse.
- HDR mode, 2 SDA falls, SDA high, SCL rises → hdr_restart_detect_o one pulse; fcnt=0 afterwards.
- SDR, 7 SDA falls with SCL low, Sr, P → target_reset_detect_o one pulse; repeat with SCL toggle between Sr and P → no pulse.
- 6 falls then Sr, P → no target reset; 8 falls → still detected.
- t_free_i=10, t_avail_i=50, t_idle_i=200 after STOP, lines high → outputs rise at 11/51/201 cycles after stop_det; SDA falls at cycle 100 → bus_free/available drop next cycle, idle never rises.
- enable_i deasserted mid-pattern and rst_ni pulsed mid-timer → all outputs 0, no spurious pulse on re-enable.

Source files
------------

// File: rtl/i3c_bus_condition_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : i3c_bus_condition_monitor
//  Function : HDR Exit / HDR Restart / Target Reset pattern detection and
//             bus-free / bus-available / bus-idle interval timers.
//  Revision : 1.0 - initial release
// ============================================================================

package i3c_bus_pkg;
  typedef struct packed {
    logic stable_high;
    logic stable_low;
    logic pos_edge;
    logic neg_edge;
  } line_state_t;

  typedef struct packed {
    line_state_t scl;
    line_state_t sda;
    logic        start_det;
    logic        stop_det;
  } bus_state_t;
endpackage

module i3c_bus_condition_monitor
  import i3c_bus_pkg::*;
#(
  parameter int TimerW          = 20,
  parameter int HdrRestartFalls = 2,
  parameter int HdrExitFalls    = 4,
  parameter int TgtRstFalls     = 7,
  parameter int CntW            = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  bus_state_t        bus_i,
  input  logic              is_in_hdr_mode_i,
  input  logic [TimerW-1:0] t_free_i,
  input  logic [TimerW-1:0] t_avail_i,
  input  logic [TimerW-1:0] t_idle_i,
  output logic              hdr_restart_detect_o,
  output logic              hdr_exit_detect_o,
  output logic              target_reset_detect_o,
  output logic              bus_free_o,
  output logic              bus_available_o,
  output logic              bus_idle_o
);

  localparam logic [CntW-1:0]   C_FCNT_MAX = '1;
  localparam logic [CntW-1:0]   C_FCNT_ONE = CntW'(1);
  localparam logic [CntW-1:0]   C_RESTART  = CntW'(HdrRestartFalls);
  localparam logic [CntW-1:0]   C_EXIT     = CntW'(HdrExitFalls);
  localparam logic [CntW-1:0]   C_TGT_RST  = CntW'(TgtRstFalls);
  localparam logic [TimerW-1:0] C_TCNT_MAX = '1;
  localparam logic [TimerW-1:0] C_TCNT_ONE = TimerW'(1);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'd0,
    TR_ARMED  = 2'd1,
    TR_WAIT_P = 2'd2
  } tr_state_e;

  tr_state_e         r_tr_state, w_tr_state_next;
  logic [CntW-1:0]   r_fcnt, w_fcnt_next;
  logic              r_exit_armed, w_exit_armed_next;
  logic [TimerW-1:0] r_tcnt, w_tcnt_next;
  logic              r_counting, w_counting_next;

  logic w_restart, w_exit, w_tgt_rst;
  logic w_free, w_avail, w_idle;

  logic w_scl_pe, w_scl_ne, w_start, w_stop, w_sda_fall, w_lines_quiet;

  assign w_scl_pe   = bus_i.scl.pos_edge;
  assign w_scl_ne   = bus_i.scl.neg_edge;
  assign w_start    = bus_i.start_det;
  assign w_stop     = bus_i.stop_det;
  assign w_sda_fall = bus_i.sda.neg_edge & bus_i.scl.stable_low;

  // Both lines must be steadily high with no edge of any kind.
  assign w_lines_quiet = bus_i.scl.stable_high & bus_i.sda.stable_high &
                         ~bus_i.scl.stable_low & ~bus_i.sda.stable_low &
                         ~bus_i.scl.pos_edge & ~bus_i.scl.neg_edge &
                         ~bus_i.sda.pos_edge & ~bus_i.sda.neg_edge;

  // Pattern counter, HDR detections and bus timer
  always_comb begin
    w_fcnt_next       = r_fcnt;
    w_exit_armed_next = r_exit_armed;
    w_tcnt_next       = r_tcnt;
    w_counting_next   = r_counting;
    w_restart         = 1'b0;
    w_exit            = 1'b0;

    if (enable_i) begin
      w_restart = is_in_hdr_mode_i & w_scl_pe & (r_fcnt == C_RESTART) &
                  bus_i.sda.stable_high;
      // The arming fall may land the cycle right before the STOP.
      w_exit = w_stop & ~w_start &
               (r_exit_armed | (is_in_hdr_mode_i & (r_fcnt >= C_EXIT)));

      if (w_scl_pe | w_start | w_stop) begin
        w_fcnt_next = '0;
      end else if (w_sda_fall && r_fcnt != C_FCNT_MAX) begin
        w_fcnt_next = r_fcnt + C_FCNT_ONE;
      end

      if (w_scl_pe | w_start | w_stop) begin
        w_exit_armed_next = 1'b0;
      end else if (is_in_hdr_mode_i && r_fcnt >= C_EXIT) begin
        w_exit_armed_next = 1'b1;
      end

      if (w_start) begin
        w_counting_next = 1'b0;
        w_tcnt_next     = '0;
      end else if (w_stop) begin
        w_counting_next = 1'b1;
        w_tcnt_next     = '0;
      end else if (!w_lines_quiet) begin
        w_counting_next = 1'b0;
        w_tcnt_next     = '0;
      end else if (r_counting && r_tcnt != C_TCNT_MAX) begin
        w_tcnt_next = r_tcnt + C_TCNT_ONE;
      end
    end else begin
      w_fcnt_next       = '0;
      w_exit_armed_next = 1'b0;
      w_tcnt_next       = '0;
      w_counting_next   = 1'b0;
    end
  end

  // Comparison uses next-state count so threshold 0 rises right after STOP.
  assign w_free  = w_counting_next & (w_tcnt_next >= t_free_i);
  assign w_avail = w_counting_next & (w_tcnt_next >= t_avail_i);
  assign w_idle  = w_counting_next & (w_tcnt_next >= t_idle_i);

  // Target Reset sequencer; reaching the fall count counts as armed at once.
  always_comb begin
    w_tr_state_next = r_tr_state;
    w_tgt_rst       = 1'b0;
    case (r_tr_state)
      TR_IDLE: begin
        if (r_fcnt >= C_TGT_RST) begin
          if (w_start) begin
            w_tr_state_next = TR_WAIT_P;
          end else if (!(w_stop | w_scl_ne)) begin
            w_tr_state_next = TR_ARMED;
          end
        end
      end
      TR_ARMED: begin
        if (w_start) begin
          w_tr_state_next = TR_WAIT_P;
        end else if (w_stop | w_scl_ne) begin
          w_tr_state_next = TR_IDLE;
        end
      end
      TR_WAIT_P: begin
        if (w_start) begin
          w_tr_state_next = TR_WAIT_P;
        end else if (w_stop) begin
          w_tr_state_next = TR_IDLE;
          w_tgt_rst       = 1'b1;
        end else if (w_scl_ne) begin
          w_tr_state_next = TR_IDLE;
        end
      end
      default: w_tr_state_next = TR_IDLE;
    endcase
    if (!enable_i) begin
      w_tr_state_next = TR_IDLE;
      w_tgt_rst       = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tr_state            <= TR_IDLE;
      r_fcnt                <= '0;
      r_exit_armed          <= 1'b0;
      r_tcnt                <= '0;
      r_counting            <= 1'b0;
      hdr_restart_detect_o  <= 1'b0;
      hdr_exit_detect_o     <= 1'b0;
      target_reset_detect_o <= 1'b0;
      bus_free_o            <= 1'b0;
      bus_available_o       <= 1'b0;
      bus_idle_o            <= 1'b0;
    end else begin
      r_tr_state            <= w_tr_state_next;
      r_fcnt                <= w_fcnt_next;
      r_exit_armed          <= w_exit_armed_next;
      r_tcnt                <= w_tcnt_next;
      r_counting            <= w_counting_next;
      hdr_restart_detect_o  <= w_restart;
      hdr_exit_detect_o     <= w_exit;
      target_reset_detect_o <= w_tgt_rst;
      bus_free_o            <= w_free;
      bus_available_o       <= w_avail;
      bus_idle_o            <= w_idle;
    end
  end

endmodule
`default_nettype wire
